pipeline_hazard_ctrl: RTL and testbench

//  Parametrised hazard/forwarding controller for the pipelined core; replaces the fixed 2-source forward + load-use stall logic.

---
 rtl/pipeline_hazard_ctrl.sv | 90 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller: tracks DEPTH in-flight writers ahead of ID, resolves
// per-operand forward selects, raises load-use stalls and counts stall/flush cycles.
module pipeline_hazard_ctrl #(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned CNT_W    = 16,
   localparam int unsigned SEL_W   = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_rs,
   input  logic [ADDR_W-1:0] id_rt,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic [ADDR_W-1:0] id_waddr,
   input  logic              ex_flush,
   output logic              stall,
   output logic              bubble,
   output logic [SEL_W-1:0]  fwd_a,
   output logic [SEL_W-1:0]  fwd_b,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);

   logic [DEPTH:1]    valid_q;
   logic [DEPTH:1]    load_q;
   logic [ADDR_W-1:0] waddr_q [DEPTH:1];

   logic [SEL_W-1:0]  sel_a, sel_b;
   logic              haz_a, haz_b;

   // Scan oldest to youngest so the smallest matching p is the one that sticks.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      haz_a = 1'b0;
      haz_b = 1'b0;
      for (int p = DEPTH; p >= 1; p--) begin
         if (id_rs_used && id_rs != '0 && valid_q[p] && waddr_q[p] == id_rs) begin
            sel_a = SEL_W'(p);
            haz_a = load_q[p] && (p < 1 + LOAD_LAT);
         end
         if (id_rt_used && id_rt != '0 && valid_q[p] && waddr_q[p] == id_rt) begin
            sel_b = SEL_W'(p);
            haz_b = load_q[p] && (p < 1 + LOAD_LAT);
         end
      end
   end

   assign stall  = enable & id_valid & (haz_a | haz_b) & ~ex_flush;
   assign bubble = enable & (stall | ex_flush);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q     <= '0;
         load_q      <= '0;
         for (int p = 1; p <= DEPTH; p++) waddr_q[p] <= '0;
         fwd_a       <= '0;
         fwd_b       <= '0;
         stall_count <= '0;
         flush_count <= '0;
      end else if (enable) begin
         for (int p = DEPTH; p >= 2; p--) begin
            valid_q[p] <= valid_q[p-1];
            load_q[p]  <= load_q[p-1];
            waddr_q[p] <= waddr_q[p-1];
         end
         if (bubble || !id_valid) begin
            valid_q[1] <= 1'b0;
            load_q[1]  <= 1'b0;
            waddr_q[1] <= '0;
         end else begin
            valid_q[1] <= id_reg_write && (id_waddr != '0);
            load_q[1]  <= id_mem_read;
            waddr_q[1] <= id_waddr;
         end
         // Producer and consumer advance together, so the distance p carries into EX.
         fwd_a <= bubble ? '0 : sel_a;
         fwd_b <= bubble ? '0 : sel_b;
         if (stall && stall_count != '1) stall_count <= stall_count + 1'b1;
         if (ex_flush && flush_count != '1) flush_count <= flush_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes expected values tagged with a cycle, a negedge monitor
// pops and compares them against two instances (DEPTH=2/LAT=1 and DEPTH=3/LAT=2, CNT_W=2).
module tb_pipeline_hazard_ctrl;

   localparam int SA = 0, BB = 1, FA = 2, FB = 3, SC = 4, FC = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b1;
   logic       id_valid, id_rs_used, id_rt_used, id_reg_write, id_mem_read, ex_flush;
   logic [4:0] id_rs, id_rt, id_waddr;

   logic        s2, b2, s3, b3;
   logic [1:0]  fa2, fb2, fa3, fb3;
   logic [15:0] sc2, fc2;
   logic [1:0]  sc3, fc3;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.ADDR_W(5), .DEPTH(2), .LOAD_LAT(1), .CNT_W(16)) dut2 (
      .clk(clk), .rst(rst), .enable(enable), .id_valid(id_valid), .id_rs(id_rs),
      .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_waddr(id_waddr),
      .ex_flush(ex_flush), .stall(s2), .bubble(b2), .fwd_a(fa2), .fwd_b(fb2),
      .stall_count(sc2), .flush_count(fc2)
   );

   pipeline_hazard_ctrl #(.ADDR_W(5), .DEPTH(3), .LOAD_LAT(2), .CNT_W(2)) dut3 (
      .clk(clk), .rst(rst), .enable(enable), .id_valid(id_valid), .id_rs(id_rs),
      .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_waddr(id_waddr),
      .ex_flush(ex_flush), .stall(s3), .bubble(b3), .fwd_a(fa3), .fwd_b(fb3),
      .stall_count(sc3), .flush_count(fc3)
   );

   typedef struct {
      int          cyc;
      int          dut;
      int          sig;
      int unsigned val;
      int          id;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   tid = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int unsigned actual(int dut, int sig);
      if (dut == 2) begin
         case (sig)
            SA: return 32'(s2);
            BB: return 32'(b2);
            FA: return 32'(fa2);
            FB: return 32'(fb2);
            SC: return 32'(sc2);
            default: return 32'(fc2);
         endcase
      end
      case (sig)
         SA: return 32'(s3);
         BB: return 32'(b3);
         FA: return 32'(fa3);
         FB: return 32'(fb3);
         SC: return 32'(sc3);
         default: return 32'(fc3);
      endcase
   endfunction

   function automatic string signame(int sig);
      case (sig)
         SA: return "stall";
         BB: return "bubble";
         FA: return "fwd_a";
         FB: return "fwd_b";
         SC: return "stall_count";
         default: return "flush_count";
      endcase
   endfunction

   always @(negedge clk) begin
      exp_t        e;
      int unsigned got;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e   = q.pop_front();
         got = actual(e.dut, e.sig);
         checks++;
         if (e.cyc != cyc || got != e.val) begin
            errors++;
            $display("FAIL t%0d dut%0d %s cyc%0d: got %0d, want %0d",
                     e.id, e.dut, signame(e.sig), e.cyc, got, e.val);
         end
      end
   end

   task automatic want(int dut, int sig, int unsigned val);
      exp_t e;
      e.cyc = cyc;
      e.dut = dut;
      e.sig = sig;
      e.val = val;
      e.id  = tid;
      q.push_back(e);
   endtask

   task automatic set_in(logic v, logic [4:0] rs, logic [4:0] rt, logic rsu, logic rtu,
                         logic rw, logic mr, logic [4:0] wa, logic fl);
      id_valid     = v;
      id_rs        = rs;
      id_rt        = rt;
      id_rs_used   = rsu;
      id_rt_used   = rtu;
      id_reg_write = rw;
      id_mem_read  = mr;
      id_waddr     = wa;
      ex_flush     = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic nop();             set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic other();           set_in(1, 1, 2, 0, 0, 0, 0, 0, 0); endtask
   task automatic alu(logic [4:0] w); set_in(1, 0, 0, 0, 0, 1, 0, w, 0); endtask
   task automatic ld(logic [4:0] w);  set_in(1, 0, 0, 0, 0, 1, 1, w, 0); endtask
   task automatic rd_a(logic [4:0] r); set_in(1, r, 0, 1, 0, 0, 0, 0, 0); endtask
   task automatic rd_b(logic [4:0] r); set_in(1, 0, r, 0, 1, 0, 0, 0, 0); endtask

   initial begin
      nop();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      tid = 0;
      want(2, SA, 0); want(2, BB, 0); want(2, FA, 0); want(2, FB, 0);
      want(2, SC, 0); want(2, FC, 0); want(3, FA, 0); want(3, SC, 0);
      tick();

      // ALU forwarding at distance 1, 2 and out of range
      tid = 1;
      alu(3);  want(2, SA, 0); tick();
      rd_a(3); want(2, SA, 0); want(2, BB, 0); tick();
      other(); want(2, FA, 1); tick();
      alu(3);  tick();
      other(); tick();
      rd_a(3); want(2, SA, 0); tick();
      other(); want(2, FA, 2); tick();
      alu(3);  tick();
      other(); tick();
      other(); tick();
      rd_a(3); tick();
      nop();   want(2, FA, 0); tick();

      // load-use on operand B
      tid = 2;
      ld(5);   tick();
      rd_b(5); want(2, SA, 1); want(2, BB, 1); tick();
      want(2, SA, 0); want(2, BB, 0); want(2, FB, 0); tick();
      nop();   want(2, FB, 2); want(2, SC, 1); tick();

      // youngest writer wins; r0 never forwards or stalls
      tid = 3;
      alu(4);  tick();
      alu(4);  tick();
      rd_a(4); want(2, SA, 0); tick();
      nop();   want(2, FA, 1); tick();
      ld(0);   tick();
      set_in(1, 0, 0, 1, 1, 0, 0, 0, 0); want(2, SA, 0); tick();
      nop();   want(2, FA, 0); want(2, FB, 0); tick();

      // flush beats a load-use stall in the same cycle
      tid = 4;
      ld(6);   tick();
      set_in(1, 6, 6, 1, 1, 0, 0, 0, 1); want(2, SA, 0); want(2, BB, 1); tick();
      nop();   want(2, FA, 0); want(2, FB, 0); want(2, FC, 1); want(2, SC, 1); tick();

      // enable=0 suppresses stall and freezes tracker and counters
      tid = 7;
      ld(9);   tick();
      enable = 1'b0;
      rd_a(9); want(2, SA, 0); want(2, BB, 0); tick();
      want(2, SA, 0); want(2, SC, 1); want(2, FC, 1); want(2, FA, 0); tick();
      enable = 1'b1;
      want(2, SA, 1); want(2, BB, 1); tick();
      want(2, SA, 0); tick();
      nop();   want(2, FA, 2); want(2, SC, 2); tick();

      // DEPTH=3, LOAD_LAT=2 instance
      tid = 5;
      rst = 1'b1; nop(); tick();
      rst = 1'b0;
      want(3, SC, 0); want(2, SC, 0); want(2, FC, 0);
      ld(7);   tick();
      rd_a(7); want(3, SA, 1); tick();
      want(3, SA, 1); want(3, BB, 1); tick();
      want(3, SA, 0); tick();
      nop();   want(3, FA, 3); want(3, SC, 2); tick();
      ld(7);   tick();
      other(); tick();
      rd_a(7); want(3, SA, 1); tick();
      want(3, SA, 0); tick();
      nop();   want(3, FA, 3); want(3, SC, 3); tick();

      // reset mid-stall, counter saturation
      tid = 6;
      ld(7);   tick();
      rd_a(7); want(3, SA, 1); tick();
      rst = 1'b1; want(3, SA, 1); want(3, SC, 3); tick();
      rst = 1'b0;
      want(3, SA, 0); want(3, BB, 0); want(3, FA, 0); want(3, SC, 0); want(3, FC, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); want(2, BB, 1);
      repeat (4) tick();
      nop();   want(3, FC, 3); want(2, FC, 4); tick();

      repeat (3) @(posedge clk);
      if (q.size() != 0) begin
         $display("FAIL scoreboard: got %0d unchecked entries, want 0", q.size());
         errors += q.size();
         checks += q.size();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
